// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: command codes, widths and one-hot state encodings shared with the cache
package burst_ram_pkg;
  localparam logic BR_CMD_READ = 1'b0;
  localparam logic BR_CMD_WRITE = 1'b1;
  localparam int BR_WORD_BITWIDTH = 64;
  localparam int BR_MASK_BITWIDTH = 8;
  localparam int BR_BURST_COUNT = 4;
  typedef enum logic [7:0] {
    ST_INIT        = 8'h01,
    ST_IDLE        = 8'h02,
    ST_READ_WAIT   = 8'h04,
    ST_READ_BURST  = 8'h08,
    ST_WRITE_BURST = 8'h10
  } br_state_e;
endpackage

// File: rtl/burst_ram_array.sv
// burst_ram_array: word array with byte write enables and one registered read port
module burst_ram_array
  import burst_ram_pkg::*;
#(
  parameter int DEPTH_BITWIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DEPTH_BITWIDTH-1:0]   addr,
  input  logic                        we,
  input  logic [BR_MASK_BITWIDTH-1:0] be,
  input  logic [BR_WORD_BITWIDTH-1:0] wdata,
  input  logic                        re,
  output logic [BR_WORD_BITWIDTH-1:0] rdata
);
  logic [BR_WORD_BITWIDTH-1:0] mem [2**DEPTH_BITWIDTH];
  // byte-granular write; contents survive reset
  always_ff @(posedge clk) begin
    if (we)
      for (int k = 0; k < BR_MASK_BITWIDTH; k++)
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
  end
  // registered read that holds its value between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/burst_ram.sv
// burst_ram: memory-side responder performing 4-beat read/write bursts with init and read latency
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int BURST_COUNT = BR_BURST_COUNT,
  parameter int CYCLES_BEFORE_DATA_VALID = 6,
  parameter int CYCLES_BEFORE_INITIATED = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd,
  input  logic                        cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0]   addr,
  input  logic [BR_WORD_BITWIDTH-1:0] wr_data,
  input  logic [BR_MASK_BITWIDTH-1:0] data_mask,
  output logic [BR_WORD_BITWIDTH-1:0] rd_data,
  output logic                        rd_data_ready,
  output logic                        busy
);
  localparam int BW = $clog2(BURST_COUNT + 1);
  localparam int CW = 16;
  localparam bit FAST = CYCLES_BEFORE_DATA_VALID == 1;
  br_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] beat, beat_n;
  logic [DEPTH_BITWIDTH-1:0] base, base_n, word;
  logic we, re, is_wr;
  assign is_wr = cmd == BR_CMD_WRITE;
  // in IDLE the first beat uses the live address; later beats wrap naturally modulo the array size
  assign word = (state == ST_IDLE) ? addr : base + DEPTH_BITWIDTH'(beat);
  // the read data register is loaded one edge before each beat, so ready tracks READ_BURST exactly
  assign rd_data_ready = state == ST_READ_BURST;
  assign busy = state != ST_IDLE;
  // state, counter, beat index and latched burst address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt <= '0;
      beat <= '0;
      base <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      beat <= beat_n;
      base <= base_n;
    end
  end
  // next-state and array strobes; beat 0 of a write is taken with the command
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    beat_n = beat;
    base_n = base;
    we = 1'b0;
    re = 1'b0;
    case (state)
      ST_INIT: begin
        state_n = (cnt == CW'(CYCLES_BEFORE_INITIATED - 1)) ? ST_IDLE : ST_INIT;
        cnt_n = (cnt == CW'(CYCLES_BEFORE_INITIATED - 1)) ? '0 : cnt + CW'(1);
      end
      ST_IDLE: begin
        if (cmd_en) begin
          base_n = addr;
          cnt_n = '0;
          beat_n = (is_wr || FAST) ? BW'(1) : '0;
          we = is_wr;
          re = !is_wr && FAST;
          state_n = is_wr ? ST_WRITE_BURST : (FAST ? ST_READ_BURST : ST_READ_WAIT);
        end
      end
      ST_READ_WAIT: begin
        if (cnt == CW'(CYCLES_BEFORE_DATA_VALID - 2)) begin
          re = 1'b1;
          beat_n = BW'(1);
          state_n = ST_READ_BURST;
        end else cnt_n = cnt + CW'(1);
      end
      ST_READ_BURST, ST_WRITE_BURST: begin
        if (beat == BW'(BURST_COUNT)) state_n = ST_IDLE;
        else begin
          re = state == ST_READ_BURST;
          we = state == ST_WRITE_BURST;
          beat_n = beat + BW'(1);
        end
      end
      default: state_n = ST_INIT;
    endcase
  end
  burst_ram_array #(.DEPTH_BITWIDTH(DEPTH_BITWIDTH)) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .addr(word),
    .we(we),
    .be(~data_mask),
    .wdata(wr_data),
    .re(re),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: randomized scenarios against an array-based reference model of the burst RAM
module tb_burst_ram;
  localparam int N = 16;
  localparam int L = 6;
  localparam int INIT = 10;
  logic clk = 1'b0, rst_n = 1'b1, cmd = 1'b0, cmd_en = 1'b0;
  logic [3:0] addr = '0;
  logic [63:0] wr_data = '0, rd_data;
  logic [7:0] data_mask = '0;
  logic rd_data_ready, busy;
  int compared = 0, mismatched = 0;
  logic [63:0] model [N];
  logic [63:0] wd [4];
  logic [7:0] wm [4];
  logic [63:0] rbuf [4];
  int r_first, r_last, r_count, r_fall, w_fall, w_ready;

  burst_ram #(.DEPTH_BITWIDTH(4), .BURST_COUNT(4), .CYCLES_BEFORE_DATA_VALID(L),
              .CYCLES_BEFORE_INITIATED(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data),
    .data_mask(data_mask), .rd_data(rd_data), .rd_data_ready(rd_data_ready), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int j = 0; j < 60 && busy; j++) tick();
    if (busy) begin
      compared++;
      mismatched++;
      $display("FAIL wait_idle: busy got 1 required 0 within 60 cycles");
    end
  endtask

  // drives a 4-beat write and records when busy drops relative to the accept edge
  task automatic do_write(input logic [3:0] a);
    wait_idle();
    w_fall = -1;
    w_ready = 0;
    for (int i = 0; i < 4; i++) begin
      cmd_en = (i == 0);
      cmd = 1'b1;
      addr = a;
      wr_data = wd[i];
      data_mask = wm[i];
      tick();
      cmd_en = 1'b0;
      w_ready += int'(rd_data_ready);
      if (!busy && w_fall < 0) w_fall = i;
    end
    for (int k = 4; k < 20 && w_fall < 0; k++) begin
      tick();
      w_ready += int'(rd_data_ready);
      if (!busy) w_fall = k;
    end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++)
        if (!wm[i][k]) model[(a + i) % N][8*k +: 8] = wd[i][8*k +: 8];
  endtask

  // issues a read and records ready window, data beats and busy fall; hold keeps a write command asserted
  task automatic do_read(input logic [3:0] a, input bit hold, input logic [3:0] ha);
    wait_idle();
    cmd_en = 1'b1;
    cmd = 1'b0;
    addr = a;
    tick();
    cmd_en = hold;
    cmd = hold;
    addr = ha;
    wr_data = {$urandom, $urandom};
    data_mask = '0;
    r_first = -1;
    r_last = -1;
    r_count = 0;
    r_fall = -1;
    for (int k = 0; k < 40; k++) begin
      if (rd_data_ready) begin
        if (r_first < 0) r_first = k;
        r_last = k;
        if (r_count < 4) rbuf[r_count] = rd_data;
        r_count++;
      end
      if (!busy) begin
        r_fall = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL reset_busy: got %b required 1", busy); end
    compared++;
    if (rd_data_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b required 0", rd_data_ready); end
    compared++;
    if (rd_data !== 64'h0) begin mismatched++; $display("FAIL reset_rd_data: got %h required 0", rd_data); end
  endtask

  task automatic test_init();
    int seen;
    rst_n = 1'b1;
    for (int j = 0; j <= INIT; j++) begin
      compared++;
      if (busy !== (j < INIT)) begin mismatched++; $display("FAIL init_busy[%0d]: got %b required %b", j, busy, j < INIT); end
      cmd_en = (j == 5);
      cmd = 1'b0;
      addr = 4'd3;
      tick();
    end
    cmd_en = 1'b0;
    seen = 0;
    repeat (15) begin
      seen += int'(rd_data_ready);
      tick();
    end
    compared++;
    if (seen != 0) begin mismatched++; $display("FAIL init_cmd_ignored: ready beats got %0d required 0", seen); end
  endtask

  task automatic test_fill();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; wm[i] = '0; end
      do_write(4'(4 * b));
      compared++;
      if (w_fall != 4) begin mismatched++; $display("FAIL fill_busy_fall: got %0d required 4", w_fall); end
      compared++;
      if (w_ready != 0) begin mismatched++; $display("FAIL fill_ready_in_write: got %0d required 0", w_ready); end
    end
  endtask

  task automatic test_write_read();
    wd[0] = {8{8'h11}}; wd[1] = {8{8'h22}}; wd[2] = {8{8'h33}}; wd[3] = {8{8'h44}};
    for (int i = 0; i < 4; i++) wm[i] = '0;
    do_write(4'd4);
    compared++;
    if (w_fall != 4) begin mismatched++; $display("FAIL wr_busy_fall: got %0d required 4", w_fall); end
    do_read(4'd4, 1'b0, 4'd0);
    compared++;
    if (r_first != L - 1) begin mismatched++; $display("FAIL rd_first_beat: got %0d required %0d", r_first, L - 1); end
    compared++;
    if (r_count != 4 || r_last != L + 2) begin mismatched++; $display("FAIL rd_window: count %0d last %0d required 4 and %0d", r_count, r_last, L + 2); end
    compared++;
    if (r_fall != L + 3) begin mismatched++; $display("FAIL rd_busy_fall: got %0d required %0d", r_fall, L + 3); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rbuf[i] !== wd[i]) begin mismatched++; $display("FAIL rd_beat%0d: got %h required %h", i, rbuf[i], wd[i]); end
    end
  endtask

  task automatic test_byte_mask();
    for (int i = 0; i < 4; i++) begin wd[i] = '1; wm[i] = '0; end
    do_write(4'd2);
    wd[0] = '0; wm[0] = 8'hF0;
    for (int i = 1; i < 4; i++) begin wd[i] = {$urandom, $urandom}; wm[i] = 8'hFF; end
    do_write(4'd2);
    do_read(4'd2, 1'b0, 4'd0);
    compared++;
    if (rbuf[0] !== 64'hFFFF_FFFF_0000_0000) begin mismatched++; $display("FAIL mask_beat0: got %h required ffffffff00000000", rbuf[0]); end
    for (int i = 1; i < 4; i++) begin
      compared++;
      if (rbuf[i] !== 64'hFFFF_FFFF_FFFF_FFFF) begin mismatched++; $display("FAIL mask_untouched%0d: got %h required all ones", i, rbuf[i]); end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; wm[i] = '0; end
    do_write(4'd14);
    do_read(4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (rbuf[i] !== wd[i + 2]) begin mismatched++; $display("FAIL wrap_low%0d: got %h required %h", i, rbuf[i], wd[i + 2]); end
    end
    do_read(4'd14, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (rbuf[i] !== wd[i]) begin mismatched++; $display("FAIL wrap_high%0d: got %h required %h", i, rbuf[i], wd[i]); end
    end
  endtask

  task automatic test_busy_reject();
    do_read(4'd8, 1'b1, 4'd3);
    compared++;
    if (r_count != 4 || r_first != L - 1) begin mismatched++; $display("FAIL reject_ready: count %0d first %0d required 4 and %0d", r_count, r_first, L - 1); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rbuf[i] !== model[(8 + i) % N]) begin mismatched++; $display("FAIL reject_beat%0d: got %h required %h", i, rbuf[i], model[(8 + i) % N]); end
    end
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; wm[i] = '0; end
    do_write(4'd12);
    compared++;
    if (w_fall != 4) begin mismatched++; $display("FAIL reject_next_accept: busy fall got %0d required 4", w_fall); end
    do_read(4'd3, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rbuf[i] !== model[(3 + i) % N]) begin mismatched++; $display("FAIL reject_no_write%0d: got %h required %h", i, rbuf[i], model[(3 + i) % N]); end
    end
  endtask

  task automatic test_reset_mid_read();
    wait_idle();
    cmd_en = 1'b1;
    cmd = 1'b0;
    addr = 4'd5;
    tick();
    cmd_en = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (rd_data_ready !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL midreset_flags: ready %b busy %b required 0 and 1", rd_data_ready, busy); end
    compared++;
    if (rd_data !== 64'h0) begin mismatched++; $display("FAIL midreset_rd_data: got %h required 0", rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    do_read(4'd5, 1'b0, 4'd0);
    compared++;
    if (r_count != 4) begin mismatched++; $display("FAIL midreset_count: got %0d required 4", r_count); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rbuf[i] !== model[(5 + i) % N]) begin mismatched++; $display("FAIL midreset_keep%0d: got %h required %h", i, rbuf[i], model[(5 + i) % N]); end
    end
  endtask

  task automatic test_random();
    logic [3:0] a;
    for (int t = 0; t < 40; t++) begin
      a = 4'($urandom_range(0, N - 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) begin
          wd[i] = {$urandom, $urandom};
          wm[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        end
        do_write(a);
        compared++;
        if (w_fall != 4 || w_ready != 0) begin mismatched++; $display("FAIL rand_write: fall %0d ready %0d required 4 and 0", w_fall, w_ready); end
      end else begin
        do_read(a, 1'b0, 4'd0);
        compared++;
        if (r_count != 4 || r_first != L - 1 || r_fall != L + 3) begin mismatched++; $display("FAIL rand_read_timing: count %0d first %0d fall %0d", r_count, r_first, r_fall); end
        for (int i = 0; i < 4; i++) begin
          compared++;
          if (rbuf[i] !== model[(a + i) % N]) begin mismatched++; $display("FAIL rand_read_beat%0d @%0d: got %h required %h", i, a, rbuf[i], model[(a + i) % N]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_fill();
    test_write_read();
    test_byte_mask();
    test_wrap();
    test_busy_reject();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
